// File: rtl/systolic_feeder_if.sv
// Handshake and data bundle between a matrix source and the systolic feeder.
interface systolic_feeder_if #(
  parameter int BITWIDTH = 4,
  parameter int N        = 4
);
  logic                               i_start;
  logic [N-1:0][N-1:0][BITWIDTH-1:0]  i_a;
  logic [N-1:0][N-1:0][BITWIDTH-1:0]  i_b;
  logic                               o_ready;
  logic                               o_doProcess;
  logic [N-1:0][BITWIDTH-1:0]         o_row;
  logic [N-1:0][BITWIDTH-1:0]         o_col;
  logic                               o_done;

  // Source side: drives the request and the matrices, observes the streams.
  modport master (
    output i_start, i_a, i_b,
    input  o_ready, o_doProcess, o_row, o_col, o_done
  );

  // Feeder side.
  modport slave (
    input  i_start, i_a, i_b,
    output o_ready, o_doProcess, o_row, o_col, o_done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Captures a matrix pair and streams it diagonally skewed into an NxN
// systolic array: row i of A is delayed by i cycles, column j of B by j.
module systolic_feeder #(
  parameter int BITWIDTH = 4,
  parameter int N        = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  systolic_feeder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

  localparam int TW = $clog2(3 * N - 2);
  localparam logic [TW-1:0] FEED_LAST  = TW'(2 * N - 2);
  localparam logic [TW-1:0] FLUSH_LAST = TW'(3 * N - 3);

  state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [N-1:0][N-1:0][BITWIDTH-1:0] a_q, a_d;
  logic [N-1:0][N-1:0][BITWIDTH-1:0] b_q, b_d;
  logic [N-1:0][BITWIDTH-1:0] row_q, row_d;
  logic [N-1:0][BITWIDTH-1:0] col_q, col_d;
  logic do_process_q, do_process_d;
  logic done_q, done_d;
  logic ready_q, ready_d;

  // Next state, step counter and matrix capture; starts outside IDLE are ignored.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = FEED;
          t_d     = '0;
          a_d     = bus.i_a;
          b_d     = bus.i_b;
        end
      end
      FEED: begin
        t_d = t_q + TW'(1);
        if (t_q == FEED_LAST) state_d = FLUSH;
      end
      FLUSH: begin
        if (t_q == FLUSH_LAST) begin
          state_d = DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are precomputed from the next state so every output comes straight from a flop.
  always_comb begin
    row_d        = '0;
    col_d        = '0;
    do_process_d = (state_d == FEED) || (state_d == FLUSH);
    done_d       = (state_d == DONE);
    ready_d      = (state_d == IDLE);
    if (do_process_d) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(t_d) == i + k) begin
            row_d[i] = a_d[i][k];
            col_d[i] = b_d[k][i];
          end
        end
      end
    end
  end

  // State and output registers; reset aborts any job and wins over a start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      t_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      do_process_q <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      a_q          <= a_d;
      b_q          <= b_d;
      row_q        <= row_d;
      col_q        <= col_d;
      do_process_q <= do_process_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
    end
  end

  assign bus.o_row       = row_q;
  assign bus.o_col       = col_q;
  assign bus.o_doProcess = do_process_q;
  assign bus.o_done      = done_q;
  assign bus.o_ready     = ready_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: an N=4 instance driven from a vector
// table plus hand-written corner sequences, and a small N=2 instance.
module tb_systolic_feeder;

  typedef struct {
    logic        dp;
    logic        rdy;
    logic        done;
    logic [15:0] row;
    logic [15:0] col;
  } vec4_t;

  // A[i][k] = 4i+k+1 truncated to 4 bits, nibble index i*4+k
  localparam logic [63:0] MAT_A   = 64'h0FED_CBA9_8765_4321;
  localparam logic [63:0] MAT_ID  = 64'h1000_0100_0010_0001;
  localparam logic [63:0] MAT_BAD = 64'h5A5A_A5A5_3C3C_C3C3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  vec4_t tbl[12];

  always #5 clk = ~clk;

  systolic_feeder_if #(.BITWIDTH(4), .N(4)) bus4 ();
  systolic_feeder_if #(.BITWIDTH(4), .N(2)) bus2 ();

  systolic_feeder #(.BITWIDTH(4), .N(4)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus4)
  );

  systolic_feeder #(.BITWIDTH(4), .N(2)) dut2 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus2)
  );

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic [63:0] a, input logic [63:0] b);
    bus4.i_start = start;
    bus4.i_a     = a;
    bus4.i_b     = b;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkIdle4(input string tag);
    checkOutput({tag, " ready"}, 32'(bus4.o_ready), 32'd1);
    checkOutput({tag, " doProcess"}, 32'(bus4.o_doProcess), 32'd0);
    checkOutput({tag, " done"}, 32'(bus4.o_done), 32'd0);
    checkOutput({tag, " row"}, 32'(bus4.o_row), 32'd0);
    checkOutput({tag, " col"}, 32'(bus4.o_col), 32'd0);
  endtask

  // One full job checked cycle by cycle; disturb pulses a late start with other data.
  task automatic runTable(input bit disturb);
    applyStimulus(1'b1, MAT_A, MAT_ID);
    stepCycle();
    applyStimulus(1'b0, disturb ? MAT_BAD : MAT_A, MAT_ID);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) stepCycle();
      checkOutput($sformatf("tbl%0d c%0d doProcess", disturb, c + 1), 32'(bus4.o_doProcess), 32'(tbl[c].dp));
      checkOutput($sformatf("tbl%0d c%0d ready", disturb, c + 1), 32'(bus4.o_ready), 32'(tbl[c].rdy));
      checkOutput($sformatf("tbl%0d c%0d done", disturb, c + 1), 32'(bus4.o_done), 32'(tbl[c].done));
      checkOutput($sformatf("tbl%0d c%0d row", disturb, c + 1), 32'(bus4.o_row), 32'(tbl[c].row));
      checkOutput($sformatf("tbl%0d c%0d col", disturb, c + 1), 32'(bus4.o_col), 32'(tbl[c].col));
      if (disturb && c == 4) applyStimulus(1'b1, MAT_BAD, MAT_BAD);
      if (disturb && c == 5) applyStimulus(1'b0, MAT_BAD, MAT_BAD);
    end
  endtask

  initial begin
    int gap;
    int readyCount;
    int doneCount;
    int firstDone;
    logic [7:0] row2Exp[6];
    logic [7:0] col2Exp[6];
    logic       dp2Exp[6];
    logic       done2Exp[6];

    // cycle: doProcess, ready, done, o_row {r3,r2,r1,r0}, o_col {c3,c2,c1,c0}
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0052, 16'h0000};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'h0963, 16'h0010};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'hDA74, 16'h0000};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'hEB80, 16'h0100};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'hFC00, 16'h0000};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h1000};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};

    // N=2, all elements 15
    dp2Exp   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    done2Exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    row2Exp  = '{8'h0F, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'h00};
    col2Exp  = '{8'h0F, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'h00};

    applyStimulus(1'b1, MAT_A, MAT_ID);
    bus2.i_start = 1'b0;
    bus2.i_a     = '1;
    bus2.i_b     = '1;
    rst_n        = 1'b0;
    stepCycle();
    stepCycle();
    $display("[TB] reset state");
    checkIdle4("reset");
    checkOutput("reset n2 ready", 32'(bus2.o_ready), 32'd1);
    applyStimulus(1'b0, MAT_A, MAT_ID);
    rst_n = 1'b1;
    stepCycle();

    $display("[TB] single job from vector table");
    runTable(1'b0);
    $display("[TB] late start and input change during job");
    runTable(1'b1);

    $display("[TB] back-to-back jobs");
    applyStimulus(1'b1, MAT_A, MAT_ID);
    readyCount = 0;
    doneCount  = 0;
    firstDone  = 0;
    gap        = 0;
    for (int c = 1; c <= 40 && doneCount < 2; c++) begin
      stepCycle();
      if (doneCount == 1 && bus4.o_ready) readyCount++;
      if (bus4.o_done) begin
        doneCount++;
        if (doneCount == 1) firstDone = c;
        else gap = c - firstDone;
      end
    end
    applyStimulus(1'b0, MAT_A, MAT_ID);
    checkOutput("b2b done pulses", 32'(doneCount), 32'd2);
    checkOutput("b2b done gap", 32'(gap), 32'd12);
    checkOutput("b2b ready between", 32'(readyCount), 32'd1);
    stepCycle();
    stepCycle();
    checkIdle4("b2b after");

    $display("[TB] reset in the middle of a job");
    applyStimulus(1'b1, MAT_A, MAT_ID);
    stepCycle();
    applyStimulus(1'b0, MAT_A, MAT_ID);
    for (int c = 0; c < 5; c++) stepCycle();
    checkOutput("midrst t5 row", 32'(bus4.o_row), 32'h0000FC00);
    rst_n = 1'b0;
    stepCycle();
    checkIdle4("midrst");
    rst_n     = 1'b1;
    doneCount = 0;
    for (int c = 0; c < 20; c++) begin
      stepCycle();
      if (bus4.o_done) doneCount++;
    end
    checkOutput("midrst no done", 32'(doneCount), 32'd0);
    checkOutput("midrst still ready", 32'(bus4.o_ready), 32'd1);

    $display("[TB] start on the reset release cycle");
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, MAT_A, MAT_ID);
    stepCycle();
    applyStimulus(1'b0, MAT_A, MAT_ID);
    checkOutput("rel start doProcess", 32'(bus4.o_doProcess), 32'd1);
    checkOutput("rel start row", 32'(bus4.o_row), 32'h00000001);
    doneCount = 0;
    for (int c = 0; c < 20 && doneCount == 0; c++) begin
      stepCycle();
      if (bus4.o_done) doneCount++;
    end
    checkOutput("rel start done seen", 32'(doneCount), 32'd1);
    stepCycle();

    $display("[TB] N=2 build, all elements 15");
    bus2.i_start = 1'b1;
    stepCycle();
    bus2.i_start = 1'b0;
    bus2.i_a     = '0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) stepCycle();
      checkOutput($sformatf("n2 c%0d doProcess", c + 1), 32'(bus2.o_doProcess), 32'(dp2Exp[c]));
      checkOutput($sformatf("n2 c%0d done", c + 1), 32'(bus2.o_done), 32'(done2Exp[c]));
      checkOutput($sformatf("n2 c%0d row", c + 1), 32'(bus2.o_row), 32'(row2Exp[c]));
      checkOutput($sformatf("n2 c%0d col", c + 1), 32'(bus2.o_col), 32'(col2Exp[c]));
    end
    checkOutput("n2 ready after", 32'(bus2.o_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
